uart_bridge_fifo: RTL and testbench
===================================

Name: uart_bridge_fifo

Overview:
Configurable full-duplex UART bridge between a host byte stream and a serial pad pair. It supersedes the fixed 8N1 unbuffered tx/rx pair used for console loopback into the processor.
- Adds parametrised data width, parity and stop bits.
- Adds TX and RX FIFOs with valid/ready handshakes.
- Adds sticky framing, parity and overrun error flags.
- Sits between the front-panel host interface and the processor's serial console pads.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 230400, line rate in bits/s; DIV = CLK_FREQ/BAUD_RATE, truncated integer, must be >= 8
DATA_BITS, 8, payload bits per frame, 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2 (TX generates all; RX checks only the first)
FIFO_DEPTH, 16, entries per FIFO, power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  host offers tx_data
tx_ready  out  1  TX FIFO not full; transfer occurs when tx_valid & tx_ready at a rising edge
rx_data  out  DATA_BITS  head of RX FIFO (first-word fall-through)
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  host pops head when rx_valid & rx_ready
pad_tx  out  1  serial out, idle high
pad_rx  in  1  serial in, asynchronous, idle high
tx_busy  out  1  serializer mid-frame or TX FIFO non-empty
err_clear  in  1  clears all sticky error flags
rx_frame_err  out  1  sticky: first stop bit sampled low
rx_parity_err  out  1  sticky: parity mismatch
rx_overrun  out  1  sticky: byte completed while RX FIFO full

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous, active-low. While rst = 0, both FIFOs are emptied and both FSMs return to IDLE.
- Reset values:
  - pad_tx = 1, tx_ready = 1, tx_busy = 0.
  - rx_valid = 0, rx_data = 0.
  - All error flags = 0.
- Reset mid-frame: the frame is aborted with no partial delivery. pad_tx is high in the first cycle after the reset edge.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY = 0) -> STOP -> IDLE or START.
  - Each bit lasts exactly DIV cycles. Data is sent LSB first.
  - A parity bit makes the count of ones across data plus parity odd (1) or even (2).
  - STOP lasts STOP_BITS*DIV cycles.
- TX latency and back-to-back:
  - When the FSM is idle and the FIFO is empty, a byte accepted at edge N drives pad_tx low from edge N+2.
  - If the FIFO is non-empty when STOP ends, START begins on the next cycle with no idle gap.
- RX path:
  - pad_rx passes through a 2-flop synchroniser.
  - In IDLE, a high-to-low transition enters START. At DIV/2 cycles the line is resampled: if high, the event is a glitch and the FSM returns to IDLE with no flag set.
  - Data, parity and stop bits are then sampled every DIV cycles, at mid-bit.
- RX frame outcomes (FSM returns to IDLE after the first stop-bit sample):
  - Stop bit low: rx_frame_err is set and the byte is discarded.
  - Parity mismatch: rx_parity_err is set and the byte is still pushed.
  - Byte valid but RX FIFO full: rx_overrun is set and the new byte is dropped; FIFO contents are unchanged.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full means the pointers differ only in the MSB; empty means they are equal.
  - tx_ready = !full. Push and pop in the same cycle are both honoured when each is individually legal.
  - On a full FIFO, a push with a simultaneous pop is refused, because tx_ready is already low.
  - An RX pop with rx_valid = 0 is ignored.
- Error flags: set by events, cleared by err_clear. If a set event and err_clear occur in the same cycle, the set wins.
- DATA_BITS < 8: rx_data and tx_data are exactly DATA_BITS wide; no padding.

Test Plan:
- 8N1, DIV = 100, pad_tx looped to pad_rx; push 0xA5 at edge N.
  - pad_tx low at N+2 for 100 cycles, then bits 1,0,1,0,0,1,0,1 at 100 cycles each, then high.
  - rx_valid rises with rx_data = 0xA5 about 950 cycles after the start edge.
- PARITY = 2, DATA_BITS = 7: send 0x03 -> parity bit 0 on pad_tx. Drive pad_rx with 0x03 and parity bit 1 -> rx_parity_err = 1, rx_data = 0x03 delivered. err_clear -> flag 0.
- FIFO_DEPTH = 4, rx_ready = 0: receive 0x11, 0x22, 0x33, 0x44, 0x55 -> rx_overrun = 1; pops return 0x11..0x44, then rx_valid = 0.
- Push 5 bytes to TX with FIFO_DEPTH = 4 while idle -> tx_ready drops after the 5th accept (the first byte has already moved to the serializer); frames are sent back-to-back with no idle gap; tx_busy falls only after the last stop bit.
- Line-level RX errors:
  - pad_rx low for 30 cycles (DIV = 100) -> no rx_valid, no flags.
  - Valid frame with stop bit forced low -> rx_frame_err = 1, rx_valid stays 0.
- Assert rst = 0 mid-frame at bit 3 -> next cycle pad_tx = 1, tx_ready = 1, rx_valid = 0, all flags 0; a fresh push then transmits normally.

Source files
------------

// File: rtl/uart_bridge_fifo.sv
// Full-duplex UART bridge: host valid/ready byte streams buffered through TX/RX FIFOs,
// configurable frame format, sticky framing/parity/overrun flags.

module uart_bridge_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o   = (wr_q == rd_q);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign dout_o    = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Read/write pointer update
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push_s) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop_s)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

module uart_bridge_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 230400,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 pad_tx,
    input  logic                 pad_rx,
    output logic                 tx_busy,
    input  logic                 err_clear,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(STOP_BITS * DIV + 1);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [BW-1:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic tx_par_q, tx_par_d, rx_par_q, rx_par_d;
    logic pad_q, pad_d, busy_q, busy_d;
    logic sync1_q, sync2_q, prev_q;
    logic frame_q, parity_q, ovr_q;
    logic tx_pop_s, tx_full_s, tx_empty_s;
    logic [DATA_BITS-1:0] tx_head_s;
    logic rx_push_s, rx_full_s, rx_empty_s;
    logic frame_set_s, par_set_s, ovr_set_s;

    uart_bridge_fifo_sync #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_valid), .din_i(tx_data), .pop_i(tx_pop_s),
        .dout_o(tx_head_s), .full_o(tx_full_s), .empty_o(tx_empty_s)
    );

    uart_bridge_fifo_sync #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push_s), .din_i(rx_shift_q), .pop_i(rx_ready),
        .dout_o(rx_data), .full_o(rx_full_s), .empty_o(rx_empty_s)
    );

    assign tx_ready = !tx_full_s;
    assign rx_valid = !rx_empty_s;
    assign pad_tx   = pad_q;
    assign tx_busy  = busy_q;
    assign rx_frame_err  = frame_q;
    assign rx_parity_err = parity_q;
    assign rx_overrun    = ovr_q;

    // TX next-state: loading from the FIFO at STOP end gives gap-free back-to-back frames
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_d = tx_head_s;
                    tx_par_d   = parity_bit(tx_head_s);
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_state_d = S_START;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + BW'(1);
                    if (tx_bit_q == LAST_BIT) tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                      tx_state_d = S_DATA;
                end else begin
                    tx_state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_STOP;
                end else begin
                    tx_state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == STOP_END) begin
                    tx_cnt_d = '0;
                    if (!tx_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_d = tx_head_s;
                        tx_par_d   = parity_bit(tx_head_s);
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_state_d = S_STOP;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // Line level and busy flag are registered one cycle behind the TX state
    always_comb begin
        case (tx_state_q)
            S_START:  pad_d = 1'b0;
            S_DATA:   pad_d = tx_shift_q[0];
            S_PARITY: pad_d = tx_par_q;
            default:  pad_d = 1'b1;
        endcase
        busy_d = (tx_state_q != S_IDLE) || !tx_empty_s;
    end

    // RX next-state: START waits half a bit to reject glitches, then samples at mid-bit
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CW'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_push_s   = 1'b0;
        frame_set_s = 1'b0;
        par_set_s   = 1'b0;
        ovr_set_s   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = S_START;
                else                    rx_state_d = S_IDLE;
            end
            S_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_state_d = S_START;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + BW'(1);
                    if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                      rx_state_d = S_DATA;
                end else begin
                    rx_state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = sync2_q;
                    rx_state_d = S_STOP;
                end else begin
                    rx_state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    par_set_s  = (PARITY != 0) && (rx_par_q != parity_bit(rx_shift_q));
                    if (!sync2_q)       frame_set_s = 1'b1;
                    else if (rx_full_s) ovr_set_s   = 1'b1;
                    else                rx_push_s   = 1'b1;
                end else begin
                    rx_state_d = S_STOP;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // State, datapath and sticky flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            rx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            rx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            rx_par_q   <= 1'b0;
            pad_q      <= 1'b1;
            busy_q     <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            frame_q    <= 1'b0;
            parity_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_bit_q   <= rx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            tx_par_q   <= tx_par_d;
            rx_par_q   <= rx_par_d;
            pad_q      <= pad_d;
            busy_q     <= busy_d;
            sync1_q    <= pad_rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            frame_q    <= frame_set_s | (frame_q & ~err_clear);
            parity_q   <= par_set_s | (parity_q & ~err_clear);
            ovr_q      <= ovr_set_s | (ovr_q & ~err_clear);
        end
    end
endmodule

// File: tb/tb_uart_bridge_fifo.sv
// Randomized bench for uart_bridge_fifo: an 8N1 and a 7E2 instance checked cycle by cycle
// against a frame model built from bit-level arithmetic.
`timescale 1ns/1ps
module tb_uart_bridge_fifo;
    localparam int DIV   = 16;
    localparam int CLKF  = 1600000;
    localparam int BAUD  = 100000;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic [1:0][7:0] txd;
    logic [1:0][7:0] rxd;
    logic [1:0] txv, rxr, errc, loop_en, drv;
    logic [1:0] txr, rxv, padtx, padrx, busy, ferr, perr, ovr;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q [$];

    always #5 clk = ~clk;

    assign padrx[0] = loop_en[0] ? padtx[0] : drv[0];
    assign padrx[1] = loop_en[1] ? padtx[1] : drv[1];
    assign rxd[1][7] = 1'b0;

    uart_bridge_fifo #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
        .rx_data(rxd[0]), .rx_valid(rxv[0]), .rx_ready(rxr[0]), .pad_tx(padtx[0]),
        .pad_rx(padrx[0]), .tx_busy(busy[0]), .err_clear(errc[0]), .rx_frame_err(ferr[0]),
        .rx_parity_err(perr[0]), .rx_overrun(ovr[0]));

    uart_bridge_fifo #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                       .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .tx_data(txd[1][6:0]), .tx_valid(txv[1]), .tx_ready(txr[1]),
        .rx_data(rxd[1][6:0]), .rx_valid(rxv[1]), .rx_ready(rxr[1]), .pad_tx(padtx[1]),
        .pad_rx(padrx[1]), .tx_busy(busy[1]), .err_clear(errc[1]), .rx_frame_err(ferr[1]),
        .rx_parity_err(perr[1]), .rx_overrun(ovr[1]));

    function automatic int db(input int d);  return (d == 0) ? 8 : 7; endfunction
    function automatic int par(input int d); return (d == 0) ? 0 : 2; endfunction
    function automatic int sb(input int d);  return (d == 0) ? 1 : 2; endfunction
    function automatic int nbits(input int d);
        return 1 + db(d) + ((par(d) != 0) ? 1 : 0) + sb(d);
    endfunction
    function automatic logic [7:0] dmask(input int d);
        return 8'((1 << db(d)) - 1);
    endfunction

    // Line level of bit idx (0 = start) of a frame carrying b
    function automatic logic frame_bit(input int d, input logic [7:0] b, input int idx);
        int ones;
        ones = $countones(b & dmask(d));
        if (idx == 0) return 1'b0;
        if (idx <= db(d)) return b[idx-1];
        if (par(d) != 0 && idx == db(d) + 1)
            return (par(d) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    // Expected pad_tx after edge N+c when the burst bq was accepted at edges N, N+1, ...
    function automatic logic exp_pad(input int d, input logic [7:0] bq [$], input int c);
        int f, k;
        f = DIV * nbits(d);
        if (c < 2 || c > 1 + bq.size() * f) return 1'b1;
        k = c - 2;
        return frame_bit(d, bq[k / f], (k % f) / DIV);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input int d, input logic f, input logic p, input logic o);
        check_eq("rx_frame_err", ferr[d], f);
        check_eq("rx_parity_err", perr[d], p);
        check_eq("rx_overrun", ovr[d], o);
    endtask

    task automatic clear_errs(input int d);
        errc[d] = 1'b1;
        tick();
        errc[d] = 1'b0;
        check_flags(d, 1'b0, 1'b0, 1'b0);
    endtask

    // Push bq back-to-back from idle in loopback, check line/busy/ready each cycle, then drain RX
    task automatic tx_burst(input int d, input logic [7:0] bq [$], input bit clr);
        int n, f, pops, occ, exp_n;
        n = bq.size();
        f = DIV * nbits(d);
        loop_en[d] = 1'b1;
        rxr[d] = 1'b0;
        for (int c = 0; c < n * f + 6; c++) begin
            if (c < n) begin
                txd[d] = bq[c];
                txv[d] = 1'b1;
            end else begin
                txv[d] = 1'b0;
            end
            tick();
            check_eq("pad_tx", padtx[d], exp_pad(d, bq, c));
            check_eq("tx_busy", busy[d], (c >= 1) && (c <= 1 + n * f));
            if (c < n) begin
                pops = 0;
                for (int j = 0; j < n; j++) if (1 + j * f <= c) pops++;
                occ = (c + 1) - pops;
                check_eq("tx_ready", txr[d], occ < DEPTH);
            end
        end
        exp_n = (n < DEPTH) ? n : DEPTH;
        check_flags(d, 1'b0, 1'b0, n > DEPTH);
        for (int i = 0; i < exp_n; i++) begin
            check_eq("rx_valid", rxv[d], 1'b1);
            check_eq("rx_data", rxd[d], bq[i] & dmask(d));
            rxr[d] = 1'b1;
            tick();
            rxr[d] = 1'b0;
        end
        check_eq("rx_drained", rxv[d], 1'b0);
        if (clr) clear_errs(d);
    endtask

    task automatic rand_burst(input int d, input int n, input bit clr);
        logic [7:0] bq [$];
        bq = {};
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom) & dmask(d));
        tx_burst(d, bq, clr);
    endtask

    // Drive one frame onto pad_rx; optionally invert parity or pull the first stop bit low
    task automatic rx_frame(input int d, input logic [7:0] b, input bit flip, input bit stop_low);
        int nb;
        logic v;
        nb = 1 + db(d) + ((par(d) != 0) ? 1 : 0) + 1;
        loop_en[d] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            v = frame_bit(d, b, i);
            if (flip && par(d) != 0 && i == db(d) + 1) v = ~v;
            if (stop_low && i == nb - 1) v = 1'b0;
            drv[d] = v;
            repeat (DIV) tick();
        end
        drv[d] = 1'b1;
        repeat (2 * DIV) tick();
    endtask

    task automatic rx_good(input int d, input logic [7:0] b, input bit flip);
        rx_frame(d, b, flip, 1'b0);
        check_flags(d, 1'b0, flip, 1'b0);
        check_eq("rx_valid", rxv[d], 1'b1);
        check_eq("rx_data", rxd[d], b & dmask(d));
        rxr[d] = 1'b1;
        tick();
        rxr[d] = 1'b0;
        check_eq("rx_popped", rxv[d], 1'b0);
        clear_errs(d);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit flip;
        rst = 1'b0;
        txd = '0;
        txv = '0;
        rxr = '0;
        errc = '0;
        loop_en = 2'b11;
        drv = 2'b11;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_pad_tx", padtx[d], 1'b1);
            check_eq("rst_tx_ready", txr[d], 1'b1);
            check_eq("rst_tx_busy", busy[d], 1'b0);
            check_eq("rst_rx_valid", rxv[d], 1'b0);
            check_eq("rst_rx_data", rxd[d], 8'h00);
            check_flags(d, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        repeat (2) tick();

        q = {};
        q.push_back(8'hA5);
        tx_burst(0, q, 1'b1);
        q = {};
        q.push_back(8'h03);
        tx_burst(1, q, 1'b1);
        for (int d = 0; d < 2; d++) begin
            rand_burst(d, 5, 1'b1);
            for (int k = 0; k < 3; k++) rand_burst(d, $urandom_range(1, 5), 1'b1);
        end

        rx_good(1, 8'h03, 1'b1);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom) & dmask(d);
                flip = (par(d) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                rx_good(d, b, flip);
            end
            rx_frame(d, 8'($urandom) & dmask(d), 1'b0, 1'b1);
            check_eq("frame_err_set", ferr[d], 1'b1);
            check_eq("frame_err_no_data", rxv[d], 1'b0);
            clear_errs(d);
            loop_en[d] = 1'b0;
            drv[d] = 1'b0;
            repeat (5) tick();
            drv[d] = 1'b1;
            repeat (2 * DIV) tick();
            check_eq("glitch_rx_valid", rxv[d], 1'b0);
            check_flags(d, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-frame with flags set, RX data buffered and TX bytes still queued
        rand_burst(0, 5, 1'b0);
        rx_frame(0, 8'h5A, 1'b0, 1'b0);
        rx_frame(1, 8'h11, 1'b0, 1'b1);
        loop_en[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            txd[0] = 8'($urandom);
            txv[0] = 1'b1;
            tick();
        end
        txv[0] = 1'b0;
        repeat (DIV * 4 + DIV / 2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check_eq("mid_rst_pad_tx", padtx[d], 1'b1);
            check_eq("mid_rst_tx_ready", txr[d], 1'b1);
            check_eq("mid_rst_tx_busy", busy[d], 1'b0);
            check_eq("mid_rst_rx_valid", rxv[d], 1'b0);
            check_flags(d, 1'b0, 1'b0, 1'b0);
        end
        repeat (2 * DIV) tick();
        rand_burst(0, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
